// File: rtl/periph_responder.sv
// Memory-mapped peripheral responder: I/O port, button, SPI master, tick counter.
// Define PERIPH_TICKS_EN to build the free-running TICKS counter at offset 0x10.
module periph_responder #(
  parameter logic [15:0] BASE_ADDR     = 16'h8000,
  parameter logic [7:0]  SPI_DIV_RESET = 8'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [31:0] data_in,
  input  logic [3:0]  write_mask,
  input  logic        bus_enable,
  input  logic        write_enable,
  output logic [31:0] data_out,
  output logic        hit,
  output logic [3:0]  ioport,
  input  logic        button_0,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} spi_state_e;

  spi_state_e  state, state_d;
  logic        sel, wr, wr_q, start, busy;
  logic [2:0]  idx;
  logic [1:0]  btn_sync;
  logic [7:0]  divisor, rx_byte, rx_d;
  logic [7:0]  shift_q, shift_d, hcnt_q, hcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        miso_q, miso_d, spi_clk_d, spi_mosi_d;
  logic [31:0] ticks, rdata;
  logic        unused;

  assign sel    = bus_enable && (address[15:8] == BASE_ADDR[15:8]);
  assign idx    = address[4:2];
  assign wr     = sel && write_enable;
  assign busy   = (state != IDLE);
  // CPU holds write strobes for several edges; only the leading edge starts SPI
  assign start  = wr && !wr_q && (idx == 3'd2) && !write_mask[0];
  assign unused = ^{address[7:5], address[1:0], data_in[31:16], write_mask[3:2]};

`ifdef PERIPH_TICKS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ticks <= '0;
    else          ticks <= ticks + 32'd1;
`else
  assign ticks = '0;
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata[3:0]  = ioport;
      3'd1: rdata[0]    = ~btn_sync[1];
      3'd2: rdata[7:0]  = rx_byte;
      3'd3: begin
        rdata[0]    = busy;
        rdata[15:8] = divisor;
      end
      3'd4: rdata = ticks;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      hit      <= 1'b0;
      wr_q     <= 1'b0;
      ioport   <= '0;
      divisor  <= SPI_DIV_RESET;
      btn_sync <= 2'b11;
    end else begin
      hit      <= sel;
      wr_q     <= wr;
      btn_sync <= {btn_sync[0], button_0};
      if (sel && !write_enable)                    data_out <= rdata;
      if (wr && idx == 3'd0 && !write_mask[0])     ioport   <= data_in[3:0];
      if (wr && idx == 3'd3 && !write_mask[1])     divisor  <= data_in[15:8];
    end
  end

  // miso is captured on the rising edge and shifted in on the following
  // falling edge, so untransmitted data bits are never overwritten.
  always_comb begin
    state_d    = state;
    shift_d    = shift_q;
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    miso_d     = miso_q;
    spi_clk_d  = spi_clk;
    spi_mosi_d = spi_mosi;
    rx_d       = rx_byte;
    case (state)
      IDLE: if (start) begin
        shift_d    = data_in[7:0];
        bcnt_d     = 3'd7;
        hcnt_d     = divisor;
        spi_clk_d  = 1'b0;
        spi_mosi_d = data_in[7];
        state_d    = LOW;
      end
      LOW: if (hcnt_q == 8'd0) begin
        spi_clk_d = 1'b1;
        miso_d    = spi_miso;
        hcnt_d    = divisor;
        state_d   = HIGH;
      end else hcnt_d = hcnt_q - 8'd1;
      HIGH: if (hcnt_q == 8'd0) begin
        spi_clk_d = 1'b0;
        shift_d   = {shift_q[6:0], miso_q};
        hcnt_d    = divisor;
        if (bcnt_q == 3'd0) state_d = DONE;
        else begin
          spi_mosi_d = shift_q[6];
          bcnt_d     = bcnt_q - 3'd1;
          state_d    = LOW;
        end
      end else hcnt_d = hcnt_q - 8'd1;
      DONE: begin
        rx_d       = shift_q;
        spi_mosi_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shift_q  <= '0;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      miso_q   <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      rx_byte  <= '0;
    end else begin
      state    <= state_d;
      shift_q  <= shift_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      miso_q   <= miso_d;
      spi_clk  <= spi_clk_d;
      spi_mosi <= spi_mosi_d;
      rx_byte  <= rx_d;
    end
  end

endmodule

// File: tb/tb_periph_responder.sv
// Bench for periph_responder: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_periph_responder;
`ifdef PERIPH_TICKS_EN
  localparam bit TICKS = 1'b1;
`else
  localparam bit TICKS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, bus_enable, write_enable, button_0, miso_rand, loop;
  logic [15:0] address;
  logic [31:0] data_in, data_out;
  logic [3:0]  write_mask, ioport;
  logic        hit, spi_clk, spi_mosi, spi_miso;

  always #5 clk = ~clk;
  assign spi_miso = loop ? spi_mosi : miso_rand;

  periph_responder dut (
    .clk(clk), .reset_n(reset_n), .address(address), .data_in(data_in),
    .write_mask(write_mask), .bus_enable(bus_enable), .write_enable(write_enable),
    .data_out(data_out), .hit(hit), .ioport(ioport), .button_0(button_0),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register values plus a transfer timeline (t = edges since start)
  logic [3:0]  m_io;
  logic [7:0]  m_div, m_rx, m_txb, m_acc, m_xdiv;
  logic        m_xon, m_prev_wr, m_h1, m_h2, m_hit, m_clk_e, m_mosi_e;
  logic [31:0] m_ticks, m_dout;
  int          m_t;

  always @(posedge clk) begin : model
    logic        s, busy_pre;
    logic [31:0] rd;
    int          d1, bi;
    if (!reset_n) begin
      m_io = 0; m_div = 8'd3; m_rx = 0; m_xon = 0; m_prev_wr = 0;
      m_h1 = 1; m_h2 = 1; m_ticks = 0; m_dout = 0; m_hit = 0; m_t = 0;
    end else begin
      s        = bus_enable && (address[15:8] == 8'h80);
      busy_pre = m_xon;
      case (address[4:2])
        3'd0:    rd = {28'h0, m_io};
        3'd1:    rd = {31'h0, ~m_h2};
        3'd2:    rd = {24'h0, m_rx};
        3'd3:    rd = {16'h0, m_div, 7'h0, busy_pre};
        3'd4:    rd = TICKS ? m_ticks : 32'h0;
        default: rd = 32'h0;
      endcase
      if (s && !write_enable) m_dout = rd;
      m_hit = s;
      if (m_xon) begin
        m_t++;
        d1 = int'(m_xdiv) + 1;
        // rising spi_clk edges occur at t = (2b+1)*(div+1) for bit b
        if (m_t % d1 == 0 && (m_t / d1) % 2 == 1 && m_t < 16 * d1)
          m_acc[7 - (m_t / d1 - 1) / 2] = spi_miso;
        if (m_t == 16 * d1 + 1) begin
          m_xon = 0;
          m_rx  = m_acc;
        end
      end
      if (s && write_enable) begin
        if (address[4:2] == 3'd0 && !write_mask[0]) m_io  = data_in[3:0];
        if (address[4:2] == 3'd3 && !write_mask[1]) m_div = data_in[15:8];
        if (address[4:2] == 3'd2 && !write_mask[0] && !m_prev_wr && !busy_pre) begin
          m_xon = 1; m_t = 0; m_txb = data_in[7:0]; m_xdiv = m_div; m_acc = 0;
        end
      end
      m_prev_wr = s && write_enable;
      m_h2      = m_h1;
      m_h1      = button_0;
      m_ticks   = m_ticks + 1;
    end
    m_clk_e = 0; m_mosi_e = 0;
    if (m_xon) begin
      d1 = int'(m_xdiv) + 1;
      if (m_t < 16 * d1) m_clk_e = ((m_t / d1) % 2) == 1;
      bi = m_t / (2 * d1);
      if (bi > 7) bi = 7;
      m_mosi_e = m_txb[7 - bi];
    end
    #1;
    chk("data_out", data_out, m_dout);
    chk("hit", hit, m_hit);
    chk("ioport", ioport, m_io);
    chk("spi_clk", spi_clk, m_clk_e);
    chk("spi_mosi", spi_mosi, m_mosi_e);
  end

  // mosi bits seen on each spi_clk rising edge
  logic [7:0] pbits = 0;
  int         pcount = 0;
  always @(posedge spi_clk) begin
    pbits  = {pbits[6:0], spi_mosi};
    pcount = pcount + 1;
  end

  task automatic drive(input logic [15:0] a, input logic we, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    address = a; write_enable = we; data_in = d; write_mask = m; bus_enable = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_enable = 1'b0; write_enable = 1'b0;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : stim
    logic [31:0] r1, r2;
    int          p0;
    logic [7:0]  up;
    logic [2:0]  ix;
    reset_n = 0; bus_enable = 0; write_enable = 0; address = 0; data_in = 0;
    write_mask = 4'hF; button_0 = 1; miso_rand = 0; loop = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_ioport", ioport, 4'h0);
    chk("rst_spi_clk", spi_clk, 1'b0);
    @(negedge clk) reset_n = 1;

    // ticks read twice, three edges apart
    drive(16'h8010, 0, 0, 0); r1 = data_out; chk("hit_rd1", hit, 1'b1);
    idle(2);
    drive(16'h8010, 0, 0, 0); r2 = data_out; chk("hit_rd2", hit, 1'b1);
    chk("ticks_delta", r2 - r1, TICKS ? 32'd3 : 32'd0);
    idle(1); chk("hit_idle", hit, 1'b0);

    // ioport write, fully masked write, readback
    drive(16'h8000, 1, 32'h0000000A, 4'b0000); idle(1); chk("io_wr", ioport, 4'hA);
    drive(16'h8000, 1, 32'hFFFFFFF5, 4'b1111); idle(1); chk("io_masked", ioport, 4'hA);
    drive(16'h8000, 0, 0, 0); chk("io_rd", data_out, 32'h0000000A);

    // divisor 0, loopback transfer of 0xA5
    drive(16'h800C, 1, 32'h0, 4'b1101); idle(1);
    loop = 1; p0 = pcount;
    drive(16'h8008, 1, 32'hA5, 4'b0000);
    drive(16'h800C, 0, 0, 0); chk("busy_e1", data_out, 32'h1);
    idle(15);
    drive(16'h800C, 0, 0, 0); chk("busy_e17", data_out, 32'h1);
    drive(16'h800C, 0, 0, 0); chk("busy_e18", data_out, 32'h0);
    chk("a5_pulses", pcount - p0, 8);
    chk("a5_bits", pbits, 8'hA5);
    drive(16'h8008, 0, 0, 0); chk("a5_rx", data_out, 32'h000000A5);
    idle(1);

    // start while busy is ignored
    p0 = pcount;
    drive(16'h8008, 1, 32'hA5, 4'b0000); idle(3);
    drive(16'h8008, 1, 32'h3C, 4'b0000); idle(25);
    chk("busy_pulses", pcount - p0, 8);
    chk("busy_bits", pbits, 8'hA5);
    drive(16'h8008, 0, 0, 0); chk("busy_rx", data_out, 32'h000000A5);
    idle(1);

    // strobe held two edges -> exactly one transfer
    p0 = pcount;
    drive(16'h8008, 1, 32'h5A, 4'b0000);
    drive(16'h8008, 1, 32'h5A, 4'b0000);
    idle(40);
    chk("hold_pulses", pcount - p0, 8);
    drive(16'h8008, 0, 0, 0); chk("hold_rx", data_out, 32'h0000005A);
    idle(1);

    // reset during bit 4 of a transfer
    drive(16'h8000, 1, 32'h5, 4'b0000); idle(1);
    p0 = pcount;
    drive(16'h8008, 1, 32'hFF, 4'b0000); idle(8);
    chk("abort_pulses", pcount - p0, 4);
    @(negedge clk); #2 reset_n = 0; #1;
    chk("abort_spi_clk", spi_clk, 1'b0);
    chk("abort_mosi", spi_mosi, 1'b0);
    chk("abort_ioport", ioport, 4'h0);
    chk("abort_data_out", data_out, 32'h0);
    @(negedge clk) reset_n = 1;
    drive(16'h8008, 0, 0, 0); chk("abort_rx", data_out, 32'h0);
    drive(16'h800C, 0, 0, 0); chk("abort_ctrl", data_out, 32'h00000300);

    // out-of-window read leaves data_out alone
    drive(16'h8000, 1, 32'h5, 4'b0000);
    drive(16'h8000, 0, 0, 0); chk("io_rd5", data_out, 32'h5);
    drive(16'h9000, 0, 0, 0);
    chk("miss_hit", hit, 1'b0);
    chk("miss_hold", data_out, 32'h5);
    idle(2);

    // randomized traffic
    loop = 0;
    repeat (3000) begin
      @(negedge clk);
      up = ($urandom % 8 == 0) ? 8'($urandom) : 8'h80;
      ix = ($urandom % 3 == 0) ? 3'd2 : 3'($urandom);
      bus_enable   = ($urandom % 8) != 0;
      write_enable = $urandom % 2;
      address      = {up, 3'($urandom), ix, 2'($urandom)};
      data_in      = $urandom;
      write_mask   = 4'($urandom);
      if (ix == 3'd3) begin
        data_in[15:8] = 8'($urandom_range(0, 3));
        if (m_xon) write_mask[1] = 1'b1;
      end
      button_0  = $urandom % 2;
      miso_rand = $urandom % 2;
    end
    idle(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
